// File: rtl/pakin_asm.sv
// pakin_asm: receive side of the packet link.
// Reassembles NPK fixed-width packets into one message {src,dst,dat,red}
// and checks its redundancy field. Good messages go to a double-buffered
// req/ack message output.
// Ports:
//   src_clk, reset          - clock (rising edge), async active-high reset
//   i0_pakio/i0_req/i0_ack  - packet input: {start flag, payload}, 4-phase
//   o0_src/dst/dat/red      - reassembled message fields
//   o0_req/o0_ack           - message output handshake, 4-phase
//   err_red, err_sync       - saturating error counters
//   busy                    - assembly in progress or output buffer full
module pakin_asm #(
  parameter int ASZ = 6,
  parameter int DSZ = 32,
  parameter int RSZ = 4,
  parameter int PSZ = 8
) (
  input  logic           src_clk,
  input  logic           reset,
  input  logic [PSZ:0]   i0_pakio,
  input  logic           i0_req,
  output logic           i0_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic [RSZ-1:0] o0_red,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic [7:0]     err_red,
  output logic [7:0]     err_sync,
  output logic           busy
);

  localparam int HSZ = 2*ASZ + DSZ;
  localparam int MSZ = HSZ + RSZ;
  localparam int NPK = (MSZ + PSZ - 1) / PSZ;
  // idx must also hold NPK, the "all chunks stored" marker
  localparam int IW  = $clog2(NPK + 1);

  typedef enum logic [1:0] {IDLE, ASM, CHK, HOLD} state_t;

  // Redundancy: bit i of the header folds into redundancy bit (i mod RSZ)
  function automatic logic [RSZ-1:0] calc_redun(input logic [HSZ-1:0] v);
    logic [RSZ-1:0] r;
    r = '0;
    for (int i = 0; i < HSZ; i++) r[i % RSZ] = r[i % RSZ] ^ v[i];
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [MSZ-1:0] msg_q, msg_d;
  logic           ack_q, ack_d;
  logic           req_q, req_d;
  logic           full_q, full_d;
  logic [ASZ-1:0] src_q, src_d, dst_q, dst_d;
  logic [DSZ-1:0] dat_q, dat_d;
  logic [RSZ-1:0] red_q, red_d;
  logic [7:0]     err_red_q, err_red_d, err_sync_q, err_sync_d;

  logic           start, accept, red_ok, copy, msg_done;
  logic [IW-1:0]  widx;
  logic [PSZ-1:0] chunk;

  assign start    = i0_pakio[PSZ];
  assign chunk    = i0_pakio[PSZ-1:0];
  assign msg_done = (idx_q == IW'(NPK));
  assign red_ok   = (calc_redun(msg_q[MSZ-1:RSZ]) == msg_q[RSZ-1:0]);
  assign accept   = i0_req && !ack_q &&
                    ((state_q == IDLE) || (state_q == ASM && !msg_done));
  assign copy     = !full_q && ((state_q == CHK && red_ok) || state_q == HOLD);

  always_ff @(posedge src_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Once the last chunk is stored ASM lingers one cycle with idx==NPK,
  // so CHK sees a settled buffer and o0_req rises two edges after it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && start) state_d = ASM;
      ASM:  if (msg_done) state_d = CHK;
      CHK:  state_d = (red_ok && full_q) ? HOLD : IDLE;
      HOLD: if (!full_q) state_d = IDLE;
    endcase
  end

  // Datapath next values: assembly buffer, handshakes, output buffer, counters
  always_comb begin
    idx_d      = idx_q;
    msg_d      = msg_q;
    ack_d      = accept ? 1'b1 : (i0_req ? ack_q : 1'b0);
    err_red_d  = err_red_q;
    err_sync_d = err_sync_q;
    widx       = start ? '0 : idx_q;

    if (accept && (start || state_q == ASM)) begin
      for (int k = 0; k < NPK; k++) begin
        if (int'(widx) == k) begin
          for (int b = 0; b < PSZ; b++) begin
            if (k*PSZ + b < MSZ) msg_d[k*PSZ + b] = chunk[b];
          end
        end
      end
      idx_d = start ? IW'(1) : idx_q + IW'(1);
    end
    if (state_q == ASM && msg_done) idx_d = '0;

    // A non-start packet in IDLE or a start packet mid-message is a framing error
    if (accept && ((state_q == IDLE && !start) || (state_q == ASM && start))
        && err_sync_q != 8'hFF)
      err_sync_d = err_sync_q + 8'd1;
    if (state_q == CHK && !red_ok && err_red_q != 8'hFF)
      err_red_d = err_red_q + 8'd1;

    // Buffer frees only once the consumer has dropped ack; a copy in that
    // same cycle sees the old full flag and waits one more cycle.
    if (copy)                             full_d = 1'b1;
    else if (full_q && !req_q && !o0_ack) full_d = 1'b0;
    else                                  full_d = full_q;
    req_d = copy ? 1'b1 : (o0_ack ? 1'b0 : req_q);
    src_d = copy ? msg_q[MSZ-1 -: ASZ]     : src_q;
    dst_d = copy ? msg_q[MSZ-1-ASZ -: ASZ] : dst_q;
    dat_d = copy ? msg_q[RSZ +: DSZ]       : dat_q;
    red_d = copy ? msg_q[RSZ-1:0]          : red_q;
  end

  always_ff @(posedge src_clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      msg_q      <= '0;
      ack_q      <= 1'b0;
      req_q      <= 1'b0;
      full_q     <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      dat_q      <= '0;
      red_q      <= '0;
      err_red_q  <= '0;
      err_sync_q <= '0;
    end else begin
      idx_q      <= idx_d;
      msg_q      <= msg_d;
      ack_q      <= ack_d;
      req_q      <= req_d;
      full_q     <= full_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      dat_q      <= dat_d;
      red_q      <= red_d;
      err_red_q  <= err_red_d;
      err_sync_q <= err_sync_d;
    end
  end

  always_comb begin
    i0_ack   = ack_q;
    o0_req   = req_q;
    o0_src   = src_q;
    o0_dst   = dst_q;
    o0_dat   = dat_q;
    o0_red   = red_q;
    err_red  = err_red_q;
    err_sync = err_sync_q;
    busy     = (state_q != IDLE) || full_q;
  end

endmodule

// File: tb/tb_pakin_asm.sv
// Testbench for pakin_asm: table of whole messages plus hand-written
// sequences for back-pressure/HOLD, framing errors, reset and saturation.
module tb_pakin_asm;

  localparam int ASZ = 6, DSZ = 32, RSZ = 4, PSZ = 8, NPK = 6;

  logic           src_clk = 1'b0;
  logic           reset;
  logic [PSZ:0]   i0_pakio;
  logic           i0_req;
  logic           i0_ack;
  logic [ASZ-1:0] o0_src, o0_dst;
  logic [DSZ-1:0] o0_dat;
  logic [RSZ-1:0] o0_red;
  logic           o0_req;
  logic           o0_ack;
  logic [7:0]     err_red, err_sync;
  logic           busy;

  pakin_asm dut (
    .src_clk(src_clk), .reset(reset),
    .i0_pakio(i0_pakio), .i0_req(i0_req), .i0_ack(i0_ack),
    .o0_src(o0_src), .o0_dst(o0_dst), .o0_dat(o0_dat), .o0_red(o0_red),
    .o0_req(o0_req), .o0_ack(o0_ack),
    .err_red(err_red), .err_sync(err_sync), .busy(busy)
  );

  always #5 src_clk = ~src_clk;

  int cyc = 0;
  always @(posedge src_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
    int             cyc;
  } rec_t;

  typedef struct {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    bit             flip;
    bit             deliver;
    int             exp_err_red;
  } vec_t;

  rec_t rxq[$];
  bit   ack_hold = 1'b0;
  logic prev_req = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference redundancy: XOR of the header's 4-bit nibbles
  function automatic logic [RSZ-1:0] ref_red(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                             input logic [DSZ-1:0] dt);
    logic [2*ASZ+DSZ-1:0] v;
    logic [RSZ-1:0] r;
    v = {s, d, dt};
    r = '0;
    for (int c = 0; c < (2*ASZ+DSZ)/RSZ; c++) r ^= v[c*RSZ +: RSZ];
    return r;
  endfunction

  // Message consumer: logs each rising o0_req, acks unless held off
  initial begin
    o0_ack = 1'b0;
    forever begin
      @(posedge src_clk); #1;
      if (o0_req && !prev_req) rxq.push_back('{o0_src, o0_dst, o0_dat, o0_red, cyc});
      prev_req = o0_req;
      if (o0_req && !o0_ack && !ack_hold) o0_ack = 1'b1;
      else if (!o0_req && o0_ack)         o0_ack = 1'b0;
    end
  end

  // One 4-phase packet transfer; returns the cycle of the accepting edge
  task automatic applyStimulus(input logic start, input logic [PSZ-1:0] data,
                               input int budget, output int acc_cyc);
    int n;
    @(posedge src_clk); #1;
    i0_pakio = {start, data};
    i0_req   = 1'b1;
    n = 0;
    do begin @(posedge src_clk); #1; n++; end while (!i0_ack && n < budget);
    acc_cyc = cyc;
    if (!i0_ack) begin
      checkOutput("pkt_ack_timeout", i0_ack, 1);
      acc_cyc = -1;
    end
    i0_req = 1'b0;
    n = 0;
    do begin @(posedge src_clk); #1; n++; end while (i0_ack && n < budget);
    if (i0_ack) checkOutput("pkt_ack_fall", i0_ack, 0);
  endtask

  task automatic send_msg(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d, input logic [DSZ-1:0] dt,
                          input bit flip, input int from_k, input int to_k, output int last_cyc);
    logic [NPK*PSZ-1:0] m;
    m = {s, d, dt, ref_red(s, d, dt) ^ {{(RSZ-1){1'b0}}, flip}};
    last_cyc = -1;
    for (int k = from_k; k <= to_k; k++) applyStimulus(k == 0, m[k*PSZ +: PSZ], 50, last_cyc);
  endtask

  task automatic expect_msg(input string name, input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                            input logic [DSZ-1:0] dt, output int rcyc);
    rec_t r;
    int n;
    n = 0;
    while (rxq.size() == 0 && n < 200) begin @(posedge src_clk); #1; n++; end
    rcyc = -1;
    if (rxq.size() == 0) begin
      checkOutput({name, "_rx_timeout"}, rxq.size(), 1);
      return;
    end
    r = rxq.pop_front();
    rcyc = r.cyc;
    checkOutput({name, "_src"}, r.src, s);
    checkOutput({name, "_dst"}, r.dst, d);
    checkOutput({name, "_dat"}, r.dat, dt);
    checkOutput({name, "_red"}, r.red, ref_red(s, d, dt));
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!o0_req && n < 100) begin @(posedge src_clk); #1; n++; end
    if (!o0_req) checkOutput({name, "_req_timeout"}, o0_req, 1);
  endtask

  vec_t vecs[6];
  int   lc, rc;

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{6'd3,  6'd1,  32'h0000_0005, 1'b0, 1'b1, 0};
    vecs[1] = '{6'd3,  6'd1,  32'h0000_0005, 1'b1, 1'b0, 1};
    vecs[2] = '{6'd3,  6'd1,  32'h0000_0005, 1'b0, 1'b1, 1};
    vecs[3] = '{6'd63, 6'd0,  32'hFFFF_FFFF, 1'b0, 1'b1, 1};
    vecs[4] = '{6'd0,  6'd63, 32'hDEAD_BEEF, 1'b1, 1'b0, 2};
    vecs[5] = '{6'd21, 6'd42, 32'h1234_5678, 1'b0, 1'b1, 2};

    reset = 1'b1; i0_req = 1'b0; i0_pakio = '0;
    repeat (3) @(posedge src_clk);
    #1;
    checkOutput("rst_i0_ack", i0_ack, 0);
    checkOutput("rst_o0_req", o0_req, 0);
    checkOutput("rst_o0_fields", {o0_src, o0_dst, o0_dat, o0_red}, 0);
    checkOutput("rst_err_red", err_red, 0);
    checkOutput("rst_err_sync", err_sync, 0);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b0;

    // Table of whole messages
    for (int v = 0; v < 6; v++) begin
      checkOutput($sformatf("v%0d_idle_busy", v), busy, 0);
      send_msg(vecs[v].src, vecs[v].dst, vecs[v].dat, vecs[v].flip, 0, NPK-1, lc);
      repeat (8) @(posedge src_clk);
      #1;
      if (vecs[v].deliver) begin
        expect_msg($sformatf("v%0d", v), vecs[v].src, vecs[v].dst, vecs[v].dat, rc);
        checkOutput($sformatf("v%0d_latency", v), rc - lc, 2);
      end else begin
        checkOutput($sformatf("v%0d_dropped", v), rxq.size(), 0);
      end
      checkOutput($sformatf("v%0d_err_red", v), err_red, vecs[v].exp_err_red);
      checkOutput($sformatf("v%0d_err_sync", v), err_sync, 0);
    end

    // Output held: message 2 parks in HOLD, message 3 is back-pressured
    ack_hold = 1'b1;
    send_msg(6'd1, 6'd2, 32'h0000_000A, 1'b0, 0, NPK-1, lc);
    wait_req("hold_a");
    send_msg(6'd4, 6'd5, 32'h0000_000B, 1'b0, 0, NPK-1, lc);
    repeat (3) @(posedge src_clk);
    #1;
    checkOutput("hold_busy", busy, 1);
    checkOutput("hold_only_a", rxq.size(), 1);
    fork
      begin
        repeat (5) @(posedge src_clk);
        #1;
        checkOutput("hold_backpressure", i0_ack, 0);
        checkOutput("hold_stable_src", o0_src, 6'd1);
        repeat (30) @(posedge src_clk);
        ack_hold = 1'b0;
      end
      begin
        logic [NPK*PSZ-1:0] mc;
        mc = {6'd7, 6'd8, 32'h0000_000C, ref_red(6'd7, 6'd8, 32'h0000_000C)};
        applyStimulus(1'b1, mc[PSZ-1:0], 200, lc);
      end
    join
    send_msg(6'd7, 6'd8, 32'h0000_000C, 1'b0, 1, NPK-1, lc);
    expect_msg("order_a", 6'd1, 6'd2, 32'h0000_000A, rc);
    expect_msg("order_b", 6'd4, 6'd5, 32'h0000_000B, rc);
    expect_msg("order_c", 6'd7, 6'd8, 32'h0000_000C, rc);
    checkOutput("hold_err_red", err_red, 2);

    // Start flag on packet 3 restarts assembly
    send_msg(6'd5, 6'd6, 32'h1111_1111, 1'b0, 0, 2, lc);
    send_msg(6'd9, 6'd10, 32'h2222_2222, 1'b0, 0, NPK-1, lc);
    expect_msg("resync", 6'd9, 6'd10, 32'h2222_2222, rc);
    checkOutput("resync_err_sync", err_sync, 1);
    applyStimulus(1'b0, 8'h55, 50, lc);
    repeat (5) @(posedge src_clk);
    #1;
    checkOutput("lone_err_sync", err_sync, 2);
    checkOutput("lone_dropped", rxq.size(), 0);
    checkOutput("lone_busy", busy, 0);

    // Reset mid-assembly
    send_msg(6'd11, 6'd12, 32'h3333_3333, 1'b0, 0, 2, lc);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstasm_busy", busy, 0);
    checkOutput("rstasm_err", {err_red, err_sync}, 0);
    checkOutput("rstasm_i0_ack", i0_ack, 0);
    @(posedge src_clk); #1 reset = 1'b0;
    send_msg(6'd13, 6'd14, 32'h4444_4444, 1'b0, 0, NPK-1, lc);
    expect_msg("after_rstasm", 6'd13, 6'd14, 32'h4444_4444, rc);

    // Reset while o0_req is high
    ack_hold = 1'b1;
    send_msg(6'd15, 6'd16, 32'h5555_5555, 1'b0, 0, NPK-1, lc);
    wait_req("rstout");
    #2 reset = 1'b1;
    #1;
    checkOutput("rstout_o0_req", o0_req, 0);
    checkOutput("rstout_fields", {o0_src, o0_dst, o0_dat, o0_red}, 0);
    @(posedge src_clk); #1 reset = 1'b0;
    ack_hold = 1'b0;
    rxq.delete();
    send_msg(6'd17, 6'd18, 32'h6666_6666, 1'b0, 0, NPK-1, lc);
    expect_msg("after_rstout", 6'd17, 6'd18, 32'h6666_6666, rc);
    checkOutput("after_rst_err", {err_red, err_sync}, 0);

    // err_red saturation
    for (int i = 0; i < 300; i++) send_msg(6'(i), 6'd2, 32'(i * 7), 1'b1, 0, NPK-1, lc);
    repeat (5) @(posedge src_clk);
    #1;
    checkOutput("sat_err_red", err_red, 8'd255);
    checkOutput("sat_dropped", rxq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
